// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants, bit-order encodings and the data-length clamp for the UART RX path
package uart_rx_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PRESC_W = 6;
  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;
  function automatic int clamp_len(input int len, input int max_len);
    return (len < 1 || len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/rx_hold_reg.sv
// rx_hold_reg: one-entry valid/ready holding register with sticky overrun (ports: CLK, RST, i_load, i_data, i_ready, i_ovr_clr, o_data, o_valid, o_overrun)
module rx_hold_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  input  logic         i_ovr_clr,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_ovr;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_data  <= i_load ? i_data : r_data;
      r_valid <= i_load | (r_valid & ~i_ready);
      r_ovr   <= (i_load & r_valid & ~i_ready) | (r_ovr & ~i_ovr_clr);
    end
  end
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;
endmodule

// File: rtl/uart_rx_deser_hs.sv
// uart_rx_deser_hs: UART RX deserializer with prescaled strobe, latched length/bit order and valid/ready output (ports: CLK, RST, deser_en, sampled_bit, edge_cnt, prescale, data_len, msb_first, data_ready, ovr_clr, P_DATA, data_valid, overrun, busy)
module uart_rx_deser_hs
  import uart_rx_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int PRESC_W = DEF_PRESC_W,
  localparam int LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               deser_en,
  input  logic               sampled_bit,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [LEN_W-1:0]   data_len,
  input  logic               msb_first,
  input  logic               data_ready,
  input  logic               ovr_clr,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               overrun,
  output logic               busy
);
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_msb;
  logic [DATA_W-1:0] r_shift;
  logic              w_strobe;
  logic              w_done;
  logic              w_msb;
  logic [LEN_W-1:0]  w_len;
  logic [DATA_W-1:0] w_nxt;
  logic [DATA_W-1:0] w_word;
  assign w_strobe = deser_en && prescale != '0 && edge_cnt == prescale - PRESC_W'(1);
  assign w_len    = (r_cnt == '0) ? LEN_W'(clamp_len(int'(data_len), DATA_W)) : r_len;
  assign w_msb    = (r_cnt == '0) ? msb_first : r_msb;
  assign w_nxt    = (w_msb == MSB_FIRST) ? {r_shift[DATA_W-2:0], sampled_bit} : {sampled_bit, r_shift[DATA_W-1:1]};
  assign w_done   = w_strobe && (r_cnt + LEN_W'(1) == w_len);
  assign w_word   = (w_msb == MSB_FIRST) ? w_nxt : w_nxt >> (LEN_W'(DATA_W) - w_len);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_msb   <= LSB_FIRST;
      r_shift <= '0;
    end else if (!deser_en || w_done) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_strobe) begin
      r_cnt   <= r_cnt + LEN_W'(1);
      r_len   <= w_len;
      r_msb   <= w_msb;
      r_shift <= w_nxt;
    end
  end
  assign busy = r_cnt != '0;
  rx_hold_reg #(.W(DATA_W)) u_hold (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (w_done),
    .i_data   (w_word),
    .i_ready  (data_ready),
    .i_ovr_clr(ovr_clr),
    .o_data   (P_DATA),
    .o_valid  (data_valid),
    .o_overrun(overrun)
  );
endmodule

// File: tb/tb_uart_rx_deser_hs.sv
// tb_uart_rx_deser_hs: directed and randomized scoreboard bench for uart_rx_deser_hs
module tb_uart_rx_deser_hs;
  localparam int DW = 8;
  localparam int PW = 6;
  localparam int LW = 4;
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          deser_en = 1'b0;
  logic          sampled_bit = 1'b0;
  logic [PW-1:0] edge_cnt = '0;
  logic [PW-1:0] prescale = 6'd8;
  logic [LW-1:0] data_len = 4'd8;
  logic          msb_first = 1'b0;
  logic          data_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          overrun;
  logic          busy;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int mon_e;
  bit sb_on = 1'b0;
  always #5 CLK = ~CLK;
  uart_rx_deser_hs #(.DATA_W(DW), .PRESC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt), .prescale(prescale), .data_len(data_len),
    .msb_first(msb_first), .data_ready(data_ready), .ovr_clr(ovr_clr),
    .P_DATA(P_DATA), .data_valid(data_valid), .overrun(overrun), .busy(busy)
  );
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic send_bit(input logic b, input bit rdy_last = 1'b0);
    deser_en = 1'b1;
    sampled_bit = b;
    for (int e = 0; e < int'(prescale); e++) begin
      edge_cnt = PW'(e);
      if (rdy_last && e == int'(prescale) - 1) data_ready = 1'b1;
      tick;
    end
    if (rdy_last) data_ready = 1'b0;
  endtask
  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask
  task automatic consume;
    deser_en = 1'b0;
    data_ready = 1'b1;
    tick;
    data_ready = 1'b0;
  endtask
  function automatic int model(input logic [15:0] bits, input int n, input bit msb);
    int w = 0;
    for (int i = 0; i < n; i++) w = msb ? w * 2 + int'(bits[i]) : w + (int'(bits[i]) << i);
    return w;
  endfunction
  always @(negedge CLK) begin
    if (sb_on && data_valid && data_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word", P_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if (P_DATA !== DW'(mon_e)) begin
          failures++;
          $display("FAIL sb_word: got 0x%0h expected 0x%0h", P_DATA, mon_e);
        end
      end
    end
  end
  initial forever begin
    @(posedge CLK);
    #1;
    if (sb_on) data_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    logic [15:0] bits;
    int len, eff, k;
    bit msb;
    tick;
    tick;
    check("rst_pdata", 32'(P_DATA), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    RST = 1'b0;
    tick;
    bits = 16'hA5;
    send(bits, 7);
    check("t1_valid_pre", 32'(data_valid), 0);
    check("t1_busy_mid", 32'(busy), 1);
    send_bit(bits[7]);
    check("t1_pdata", 32'(P_DATA), 32'hA5);
    check("t1_valid", 32'(data_valid), 1);
    check("t1_busy", 32'(busy), 0);
    consume;
    check("t1_consumed", 32'(data_valid), 0);
    prescale = 6'd16;
    data_len = 4'd5;
    msb_first = 1'b1;
    bits = 16'h000D;
    send(bits, 2);
    data_len = 4'd7;
    for (int i = 2; i < 5; i++) send_bit(bits[i]);
    check("t2_pdata", 32'(P_DATA), 32'h16);
    check("t2_valid", 32'(data_valid), 1);
    consume;
    prescale = 6'd4;
    data_len = 4'd8;
    msb_first = 1'b0;
    send(16'h3C, 8);
    check("t3_first", 32'(P_DATA), 32'h3C);
    check("t3_ovr0", 32'(overrun), 0);
    send(16'hC3, 8);
    check("t3_pdata", 32'(P_DATA), 32'hC3);
    check("t3_ovr", 32'(overrun), 1);
    check("t3_valid", 32'(data_valid), 1);
    deser_en = 1'b0;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 0);
    check("t3_valid_kept", 32'(data_valid), 1);
    bits = 16'h5A;
    send(bits, 7);
    send_bit(bits[7], 1'b1);
    check("t3_rdy_pdata", 32'(P_DATA), 32'h5A);
    check("t3_rdy_valid", 32'(data_valid), 1);
    check("t3_rdy_ovr", 32'(overrun), 0);
    consume;
    check("t3_consumed", 32'(data_valid), 0);
    send(16'hFF, 4);
    check("t4_busy_mid", 32'(busy), 1);
    deser_en = 1'b0;
    tick;
    check("t4_busy", 32'(busy), 0);
    check("t4_valid", 32'(data_valid), 0);
    check("t4_pdata", 32'(P_DATA), 32'h5A);
    send(16'h81, 8);
    check("t4_next", 32'(P_DATA), 32'h81);
    check("t4_next_valid", 32'(data_valid), 1);
    consume;
    send(16'h11, 8);
    send(16'h22, 8);
    check("t5_pre_ovr", 32'(overrun), 1);
    send(16'h07, 3);
    check("t5_pre_busy", 32'(busy), 1);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("t5_pdata", 32'(P_DATA), 0);
    check("t5_valid", 32'(data_valid), 0);
    check("t5_ovr", 32'(overrun), 0);
    check("t5_busy", 32'(busy), 0);
    prescale = 6'd0;
    deser_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      edge_cnt = PW'($urandom);
      sampled_bit = 1'($urandom);
      tick;
    end
    check("t6_p0_busy", 32'(busy), 0);
    check("t6_p0_valid", 32'(data_valid), 0);
    prescale = 6'd1;
    bits = 16'hB4;
    send(bits, 7);
    check("t6_p1_valid_pre", 32'(data_valid), 0);
    send_bit(bits[7]);
    check("t6_p1_pdata", 32'(P_DATA), 32'hB4);
    check("t6_p1_valid", 32'(data_valid), 1);
    consume;
    sb_on = 1'b1;
    for (int w = 0; w < 40; w++) begin
      len = int'($urandom_range(0, 15));
      if (len >= 1 && len <= 4) len += 4;
      eff = (len == 0 || len > DW) ? DW : len;
      msb = 1'($urandom);
      bits = 16'($urandom);
      prescale = PW'($urandom_range(1, 10));
      data_len = LW'(len);
      msb_first = msb;
      exp_q.push_back(model(bits, eff, msb));
      for (int i = 0; i < eff; i++) begin
        send_bit(bits[i]);
        if (i == 1) begin
          data_len = LW'($urandom);
          msb_first = 1'($urandom);
        end
      end
      deser_en = 1'b0;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
        tick;
        k++;
      end
      check("sb_drain", 32'(exp_q.size()), 0);
    end
    sb_on = 1'b0;
    tick;
    data_ready = 1'b0;
    check("rand_ovr", 32'(overrun), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
